// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared widths, FSM state encoding and operand-pair type for the
//            calculator dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

   localparam int c_OP_W  = 8;
   localparam int c_RES_W = 16;

   typedef logic [2:0] state_t;

   localparam state_t c_ST_IDLE      = 3'd0;
   localparam state_t c_ST_START     = 3'd1;
   localparam state_t c_ST_WAIT_BUSY = 3'd2;
   localparam state_t c_ST_WAIT_DONE = 3'd3;
   localparam state_t c_ST_HOLD      = 3'd4;

   // Operand a sits in the upper half of a FIFO entry.
   typedef struct packed {
      logic [c_OP_W-1:0] a;
      logic [c_OP_W-1:0] b;
   } op_pair_t;

endpackage
`default_nettype wire

// File: rtl/calc_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_dispatcher_if
// Purpose  : Operand input, calculator and result handshake signals of the
//            dispatcher. slave = dispatcher view, master = environment view.
// Revision : 1.0 - initial release
// ============================================================================
interface calc_dispatcher_if;
   import calc_pkg::*;

   logic                 in_valid_i;
   logic                 in_ready_o;
   logic [c_OP_W-1:0]    in_a_i;
   logic [c_OP_W-1:0]    in_b_i;
   logic                 calc_start_o;
   logic [c_OP_W-1:0]    calc_a_o;
   logic [c_OP_W-1:0]    calc_b_o;
   logic                 calc_busy_i;
   logic [c_RES_W-1:0]   calc_y_i;
   logic                 out_valid_o;
   logic                 out_ready_i;
   logic [c_RES_W-1:0]   out_y_o;

   modport slave (
      input  in_valid_i, in_a_i, in_b_i, calc_busy_i, calc_y_i, out_ready_i,
      output in_ready_o, calc_start_o, calc_a_o, calc_b_o, out_valid_o, out_y_o
   );

   modport master (
      output in_valid_i, in_a_i, in_b_i, calc_busy_i, calc_y_i, out_ready_i,
      input  in_ready_o, calc_start_o, calc_a_o, calc_b_o, out_valid_o, out_y_o
   );

endinterface
`default_nettype wire

// File: rtl/op_fifo.sv
`default_nettype none
// ============================================================================
// Module   : op_fifo
// Purpose  : Power-of-two synchronous FIFO with occupancy count. Push when
//            full and pop when empty are ignored; the head is read
//            combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module op_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  wire logic                     clk_i,
   input  wire logic                     rst_i,
   input  wire logic                     push,
   input  wire logic                     pop,
   input  wire logic [WIDTH-1:0]         din,
   output logic      [WIDTH-1:0]         dout,
   output logic                          full,
   output logic                          empty,
   output logic      [$clog2(DEPTH):0]   count
);

   localparam int                 c_PTR_W = $clog2(DEPTH);
   localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W:0]   r_count;
   logic               w_do_push;
   logic               w_do_pop;

   assign full      = (r_count == c_FULL);
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign dout      = r_mem[r_rd_ptr];
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   // Storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge clk_i) begin
      if (w_do_push) r_mem[r_wr_ptr] <= din;
   end

   // Pointers wrap naturally at DEPTH; simultaneous push/pop keeps the count.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/calc_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : calc_dispatcher
// Purpose  : Queues operand pairs and feeds them one at a time to an external
//            multi-cycle calculator, capturing each result for a downstream
//            valid/ready consumer.
// Options  : CALC_DISPATCHER_TIMEOUT_EN - abort a calculator operation after
//            TIMEOUT wait cycles and raise the sticky err_o flag.
// Revision : 1.0 - initial release
// ============================================================================
module calc_dispatcher
   import calc_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  wire logic                    clk_i,
   input  wire logic                    rst_i,
   calc_dispatcher_if.slave             bus,
   output logic      [$clog2(DEPTH):0]  count_o,
   output logic                         err_o
);

   if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1))
   begin : g_bad_params
      $error("calc_dispatcher: DEPTH must be a power of two in 2..16 and TIMEOUT >= 1");
   end

   state_t              r_state;
   state_t              w_next;
   op_pair_t            w_in_pair;
   op_pair_t            w_head;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic                w_fifo_pop;
   logic                w_start;
   logic                w_load_y;
   logic                w_out_valid;
   logic                w_tmo_drop;
   logic [c_OP_W-1:0]   r_calc_a;
   logic [c_OP_W-1:0]   r_calc_b;
   logic [c_RES_W-1:0]  r_out_y;

   assign w_in_pair = {bus.in_a_i, bus.in_b_i};

   op_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(op_pair_t))
   ) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (bus.in_valid_i),
      .pop   (w_fifo_pop),
      .din   (w_in_pair),
      .dout  (w_head),
      .full  (w_fifo_full),
      .empty (w_fifo_empty),
      .count (count_o)
   );

`ifdef CALC_DISPATCHER_TIMEOUT_EN
   localparam int                  c_TMO_W    = $clog2(TIMEOUT + 1);
   localparam logic [c_TMO_W-1:0]  c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

   logic [c_TMO_W-1:0]  r_tmo_cnt;
   logic                r_err;
   logic                w_waiting;

   assign w_waiting  = (r_state == c_ST_WAIT_BUSY) || (r_state == c_ST_WAIT_DONE);
   // A normal exit in the last allowed cycle still wins over the timeout.
   assign w_tmo_drop = (r_tmo_cnt == c_TMO_LAST) &&
                       (((r_state == c_ST_WAIT_BUSY) && !bus.calc_busy_i) ||
                        ((r_state == c_ST_WAIT_DONE) &&  bus.calc_busy_i));
   assign err_o      = r_err;

   // Wait-cycle counter, restarted whenever the FSM is outside the wait states.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_tmo_cnt <= '0;
         r_err     <= 1'b0;
      end else begin
         r_tmo_cnt <= w_waiting ? r_tmo_cnt + 1'b1 : '0;
         if (w_tmo_drop) r_err <= 1'b1;
      end
   end
`else
   assign w_tmo_drop = 1'b0;
   assign err_o      = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) r_state <= c_ST_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         c_ST_IDLE:      if (!w_fifo_empty) w_next = c_ST_START;
         c_ST_START:     w_next = c_ST_WAIT_BUSY;
         c_ST_WAIT_BUSY: if (bus.calc_busy_i)  w_next = c_ST_WAIT_DONE;
                         else if (w_tmo_drop)  w_next = c_ST_IDLE;
         c_ST_WAIT_DONE: if (!bus.calc_busy_i) w_next = c_ST_HOLD;
                         else if (w_tmo_drop)  w_next = c_ST_IDLE;
         c_ST_HOLD:      if (bus.out_ready_i)  w_next = c_ST_IDLE;
         default:        w_next = c_ST_IDLE;
      endcase
   end

   // Output decode; out_valid is exactly "in HOLD", so IDLE never sees it set.
   always_comb begin
      w_fifo_pop  = 1'b0;
      w_start     = 1'b0;
      w_load_y    = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         c_ST_IDLE:      w_fifo_pop  = !w_fifo_empty;
         c_ST_START:     w_start     = 1'b1;
         c_ST_WAIT_DONE: w_load_y    = !bus.calc_busy_i;
         c_ST_HOLD:      w_out_valid = 1'b1;
         default:        w_fifo_pop  = 1'b0;
      endcase
   end

   // Operands latch on pop and stay put until the next pop, covering the
   // calculator's late sampling; the result latches on completion only.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_calc_a <= '0;
         r_calc_b <= '0;
         r_out_y  <= '0;
      end else begin
         if (w_fifo_pop) begin
            r_calc_a <= w_head.a;
            r_calc_b <= w_head.b;
         end
         if (w_load_y) r_out_y <= bus.calc_y_i;
      end
   end

   assign bus.in_ready_o   = !w_fifo_full;
   assign bus.calc_start_o = w_start;
   assign bus.calc_a_o     = r_calc_a;
   assign bus.calc_b_o     = r_calc_b;
   assign bus.out_valid_o  = w_out_valid;
   assign bus.out_y_o      = r_out_y;

endmodule
`default_nettype wire

// File: tb/tb_calc_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_dispatcher
// Purpose  : Self-checking bench for calc_dispatcher. A behavioural calculator
//            computes y = a*a + floor(cbrt(b)) with random latency; a queue of
//            expected results follows every accepted operand pair.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_dispatcher;
   import calc_pkg::*;

   localparam int c_DEPTH   = 4;
   localparam int c_TIMEOUT = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic [$clog2(c_DEPTH):0] count;
   logic err;

   always #5 clk = ~clk;

   calc_dispatcher_if bus();

   calc_dispatcher #(
      .DEPTH   (c_DEPTH),
      .TIMEOUT (c_TIMEOUT)
   ) u_dut (
      .clk_i   (clk),
      .rst_i   (rst_n),
      .bus     (bus),
      .count_o (count),
      .err_o   (err)
   );

   int n_checks  = 0;
   int n_fail    = 0;
   int n_starts  = 0;
   int max_count = 0;
   int exp_q[$];
   bit calc_hang   = 1'b0;
   bit rand_mode   = 1'b0;
   bit ready_fixed = 1'b0;

   function automatic int icbrt(int v);
      int r = 0;
      while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   function automatic int calc_f(int a, int b);
      return a * a + icbrt(b);
   endfunction

   task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Scoreboard: accepted pairs enqueue their result, delivered results dequeue.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.in_valid_i && bus.in_ready_o)
            exp_q.push_back(calc_f(int'(bus.in_a_i), int'(bus.in_b_i)));
         if (bus.out_valid_o && bus.out_ready_i) begin
            if (exp_q.size() == 0) check_val("out_unexpected", 32'(bus.out_y_o), 32'hFFFF_FFFF);
            else                   check_val("out_y_order", 32'(bus.out_y_o), 32'(exp_q.pop_front()));
         end
         if (bus.calc_start_o) n_starts++;
         if (int'(count) > max_count) max_count = int'(count);
      end
   end

   // Behavioural calculator: operands are sampled only at completion.
   initial begin
      bus.calc_busy_i = 1'b0;
      bus.calc_y_i    = '0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && bus.calc_start_o === 1'b1) begin
            if (calc_hang) begin
               bus.calc_busy_i = 1'b1;
               while (calc_hang) @(negedge clk);
               bus.calc_busy_i = 1'b0;
            end else begin
               repeat ($urandom_range(0, 2)) @(negedge clk);
               bus.calc_busy_i = 1'b1;
               repeat ($urandom_range(2, 5)) @(negedge clk);
               bus.calc_y_i    = 16'(calc_f(int'(bus.calc_a_o), int'(bus.calc_b_o)));
               bus.calc_busy_i = 1'b0;
            end
         end
      end
   end

   // Downstream ready: fixed level or random back-pressure.
   initial begin
      bus.out_ready_i = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready_i = rand_mode ? ($urandom_range(0, 3) != 0) : ready_fixed;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_op(input logic [7:0] a, input logic [7:0] b);
      int t = 0;
      bus.in_valid_i = 1'b1;
      bus.in_a_i     = a;
      bus.in_b_i     = b;
      @(negedge clk);
      while (!bus.in_ready_o && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) check_val("push_wait_budget", 32'(t), 32'(0));
      tick();
      bus.in_valid_i = 1'b0;
   endtask

   task automatic wait_result(string tag, int exp);
      int t = 0;
      @(negedge clk);
      while (!bus.out_valid_o && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) check_val({tag, "_budget"}, 32'(t), 32'(0));
      else          check_val(tag, 32'(bus.out_y_o), 32'(exp));
      tick();
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || bus.out_valid_o) && t < 3000) begin
         tick();
         t++;
      end
      if (t >= 3000) check_val("drain_budget", 32'(exp_q.size()), 32'(0));
      repeat (4) tick();
   endtask

   initial begin
      int s0;
      int t;
      bit saw_valid;
      rst_n          = 1'b0;
      bus.in_valid_i = 1'b0;
      bus.in_a_i     = '0;
      bus.in_b_i     = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_out_valid",  32'(bus.out_valid_o),  32'(0));
      check_val("rst_calc_start", 32'(bus.calc_start_o), 32'(0));
      check_val("rst_count",      32'(count),            32'(0));
      check_val("rst_err",        32'(err),              32'(0));
      check_val("rst_calc_a",     32'(bus.calc_a_o),     32'(0));
      check_val("rst_calc_b",     32'(bus.calc_b_o),     32'(0));
      check_val("rst_out_y",      32'(bus.out_y_o),      32'(0));
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check_val("ready_after_reset", 32'(bus.in_ready_o), 32'(1));
      tick();

      // Single operation
      ready_fixed = 1'b1;
      tick();
      s0 = n_starts;
      push_op(8'd3, 8'd27);
      wait_result("single_y", 12);
      drain();
      check_val("single_starts", 32'(n_starts - s0), 32'(1));

      // Extremes
      push_op(8'd255, 8'd255);
      wait_result("max_y", 65031);
      push_op(8'd0, 8'd0);
      wait_result("zero_y", 0);
      drain();

      // Back-pressure: result held, FIFO fills
      ready_fixed = 1'b0;
      repeat (2) tick();
      s0 = n_starts;
      for (int i = 0; i < 5; i++) push_op(8'(10 + i), 8'(37 * i));
      repeat (20) tick();
      @(negedge clk);
      check_val("bp_count_full", 32'(count),            32'(c_DEPTH));
      check_val("bp_ready_low",  32'(bus.in_ready_o),   32'(0));
      check_val("bp_out_valid",  32'(bus.out_valid_o),  32'(1));
      check_val("bp_one_start",  32'(n_starts - s0),    32'(1));
      tick();
      bus.in_valid_i = 1'b1;
      bus.in_a_i     = 8'd99;
      bus.in_b_i     = 8'd99;
      repeat (3) tick();
      bus.in_valid_i = 1'b0;
      @(negedge clk);
      check_val("bp_push_when_full_ignored", 32'(count), 32'(c_DEPTH));
      tick();
      ready_fixed = 1'b1;
      drain();
      check_val("bp_total_starts", 32'(n_starts - s0), 32'(5));

      // Wrap-around streaming
      for (int i = 0; i < 10; i++) push_op(8'(i), 8'((i * i * i) % 256));
      drain();

      // Random traffic with random downstream stalls
      rand_mode = 1'b1;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         push_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      end
      rand_mode = 1'b0;
      drain();
      check_val("count_max_le_depth", 32'(max_count <= c_DEPTH), 32'(1));
      check_val("queue_empty_after_random", 32'(exp_q.size()), 32'(0));

`ifdef CALC_DISPATCHER_TIMEOUT_EN
      // Calculator never finishes: operation dropped, err sticky
      calc_hang = 1'b1;
      saw_valid = 1'b0;
      t = 0;
      push_op(8'd7, 8'd8);
      while (!err && t < 60) begin
         @(negedge clk);
         if (bus.out_valid_o) saw_valid = 1'b1;
         t++;
      end
      check_val("tmo_err_set",     32'(err),       32'(1));
      check_val("tmo_no_output",   32'(saw_valid), 32'(0));
      check_val("tmo_not_early",   32'(t >= c_TIMEOUT && t <= c_TIMEOUT + 4), 32'(1));
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      calc_hang = 1'b0;
      repeat (3) tick();
      push_op(8'd5, 8'd125);
      wait_result("tmo_next_op_y", 30);
      drain();
      check_val("tmo_err_sticky", 32'(err), 32'(1));
`endif

      // Reset while waiting on the calculator with entries queued
      calc_hang = 1'b1;
      for (int i = 0; i < 4; i++) push_op(8'(20 + i), 8'(i + 1));
      t = 0;
      @(negedge clk);
      while (!(count == 3 && bus.calc_busy_i) && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) check_val("rstmid_setup_budget", 32'(count), 32'(3));
      tick();
      rst_n = 1'b0;
      exp_q.delete();
      #2;
      check_val("rstmid_count",     32'(count),           32'(0));
      check_val("rstmid_out_valid", 32'(bus.out_valid_o), 32'(0));
      check_val("rstmid_calc_a",    32'(bus.calc_a_o),    32'(0));
      calc_hang = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      s0 = n_starts;
      repeat (20) tick();
      @(negedge clk);
      check_val("rstmid_no_start",  32'(n_starts - s0),    32'(0));
      check_val("rstmid_count_idle", 32'(count),           32'(0));
      check_val("rstmid_valid_idle", 32'(bus.out_valid_o), 32'(0));

`ifndef CALC_DISPATCHER_TIMEOUT_EN
      check_val("err_tied_low", 32'(err), 32'(0));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/calc_dispatcher.md
CALC_DISPATCHER -- requirements
Module: calc_dispatcher

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum calculator wait cycles (used only with REQ-026).
REQ-003 SHALL have port clk_i input 1, single clock, all state on rising edge.
REQ-004 SHALL have port rst_i input 1, reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid_i input 1, upstream operand pair valid.
REQ-006 SHALL have port in_ready_o output 1, FIFO not full.
REQ-007 SHALL have ports in_a_i and in_b_i input 8 each, operands a and b.
REQ-008 SHALL have port calc_start_o output 1, start pulse to calculator.
REQ-009 SHALL have ports calc_a_o and calc_b_o output 8 each, operands held for the calculator.
REQ-010 SHALL have port calc_busy_i input 1, calculator busy.
REQ-011 SHALL have port calc_y_i input 16, calculator result.
REQ-012 SHALL have port out_valid_o output 1, result valid.
REQ-013 SHALL have port out_ready_i input 1, downstream accepts result.
REQ-014 SHALL have port out_y_o output 16, captured result.
REQ-015 SHALL have port count_o output clog2(DEPTH)+1, FIFO occupancy.
REQ-016 SHALL have port err_o output 1, sticky timeout flag.

Function
REQ-017 SHALL push {a,b} on an edge where in_valid_i and in_ready_o are both 1; in_ready_o = (count_o != DEPTH); push when full is ignored.
REQ-018 SHALL implement FSM IDLE -> START -> WAIT_BUSY -> WAIT_DONE -> HOLD -> IDLE.
REQ-019 IDLE: if FIFO not empty and out_valid_o = 0, pop head into calc_a_o/calc_b_o and go to START; otherwise remain in IDLE.
REQ-020 START: calc_start_o = 1 for exactly this one cycle, then go to WAIT_BUSY.
REQ-021 WAIT_BUSY: go to WAIT_DONE on the first cycle with calc_busy_i = 1.
REQ-022 WAIT_DONE: on the first cycle with calc_busy_i = 0, register calc_y_i into out_y_o, set out_valid_o, and go to HOLD.
REQ-023 HOLD: when out_valid_o and out_ready_i are both 1, clear out_valid_o and go to IDLE; out_y_o stays stable while out_valid_o = 1.
REQ-024 SHALL hold calc_a_o/calc_b_o constant from the pop until WAIT_DONE exits, because the calculator samples operands late.
REQ-025 A simultaneous push and pop SHALL leave count_o unchanged; FIFO pointers SHALL wrap modulo DEPTH; push and pop of the same entry in one cycle are legal when the FIFO is non-empty.

Configuration
REQ-026 With CALC_DISPATCHER_TIMEOUT_EN defined:
- a counter SHALL run in WAIT_BUSY and WAIT_DONE;
- after TIMEOUT cycles without exiting, the block SHALL set err_o, drop the operation (no output), and go to IDLE.
REQ-027 Without CALC_DISPATCHER_TIMEOUT_EN, err_o SHALL be tied 0, no counter SHALL exist, and the block SHALL wait indefinitely.

Reset
REQ-028 rst_i = 0 SHALL asynchronously clear:
- FSM -> IDLE;
- FIFO pointers and count_o -> 0;
- calc_start_o, out_valid_o, err_o -> 0;
- out_y_o, calc_a_o, calc_b_o -> 0.
REQ-029 After release, in_ready_o SHALL be 1 on the first cycle.
REQ-030 Reset mid-operation SHALL discard all queued and in-flight operands.

Structure
REQ-031 A shared package calc_pkg SHALL hold the FSM state encoding, operand width 8, and result width 16.
REQ-032 The FIFO SHALL be a sub-module op_fifo (DEPTH and width parameters, push/pop/full/empty/count).

Verification
REQ-033 Single op: push a=3, b=27 with out_ready_i = 1 -> calc_start_o pulses once; out_y_o = 12 after calculator completion.
REQ-034 Extremes: push a=255, b=255 -> out_y_o = 65031; push a=0, b=0 -> out_y_o = 0.
REQ-035 Back-pressure: push 5 pairs with DEPTH = 4 and out_ready_i = 0 -> in_ready_o = 0 after 4 accepted; exactly one calc_start_o; results appear in push order once out_ready_i = 1.
REQ-036 Wrap: push 10 pairs (a=i, b=i*i*i mod 256) in streaming mode -> ordered, correct results; count_o never exceeds DEPTH.
REQ-037 Timeout (macro on, TIMEOUT = 8): hold calc_busy_i = 1 -> err_o = 1 after 8 cycles, no out_valid_o, next op proceeds.
REQ-038 Reset in WAIT_DONE with 3 entries queued -> count_o = 0, out_valid_o = 0, no further calc_start_o.
